alu_control_sequencer: RTL and testbench

- Multicycle control unit that drives the 8-bit ALU and the 8x8 register file.
- Accepts one 32-bit instruction per handshake and decodes it into ALU opcode, register addresses, immediate and operand-select controls.
- Sequences each instruction through DECODE, EXECUTE and WRITEBACK, producing a single-cycle register-file write strobe.
- Sits between the instruction source (fetch stage or testbench) and the ALU/register-file datapath.

---
 rtl/alu_control_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_sequencer.sv
// Multicycle control unit sequencing ALU/register-file instructions through DECODE, EXECUTE and WRITEBACK.
// Build option ALU_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT with a sticky ILLEGAL flag.
module alu_control_sequencer #(
  parameter int DATA_W      = 8,
  parameter int REG_ADDR_W  = 3,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           INSTRUCTION,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  output logic [2:0]            ALUOP,
  output logic [REG_ADDR_W-1:0] READREG1,
  output logic [REG_ADDR_W-1:0] READREG2,
  output logic [REG_ADDR_W-1:0] WRITEREG,
  output logic [DATA_W-1:0]     IMMEDIATE,
  output logic                  IMM_SEL,
  output logic                  NEG_SEL,
  output logic                  WRITEENABLE,
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  output logic                  ILLEGAL,
`endif
  output logic                  BUSY
);

  localparam int EXEC_N = (EXEC_CYCLES < 1) ? 1 : ((EXEC_CYCLES > 4) ? 4 : EXEC_CYCLES);
  localparam logic [2:0] EXEC_LOAD = 3'(EXEC_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] instr_p0;
  logic [2:0]  exec_cnt;
  logic        op_legal;
  logic [2:0]  op_aluop;
  logic        op_imm;
  logic        op_neg;
  logic        unused_instr;

  // Only some bits of each byte field reach the outputs.
  assign unused_instr = ^instr_p0;

  // Stage p0: instruction latch, loaded on the accepting handshake
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && INSTR_VALID) begin
      instr_p0 <= INSTRUCTION;
    end
  end

  always_comb begin
    op_legal = 1'b1;
    op_aluop = 3'b000;
    op_imm   = 1'b0;
    op_neg   = 1'b0;
    case (instr_p0[31:24])
      8'h00: op_imm = 1'b1;
      8'h01: op_aluop = 3'b000;
      8'h02: op_aluop = 3'b001;
      8'h03: begin
        op_aluop = 3'b001;
        op_neg   = 1'b1;
      end
      8'h04: op_aluop = 3'b010;
      8'h05: op_aluop = 3'b011;
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    INSTR_READY = 1'b0;
    BUSY        = 1'b1;
    WRITEENABLE = 1'b0;
    case (state)
      S_IDLE: begin
        INSTR_READY = 1'b1;
        BUSY        = 1'b0;
        if (INSTR_VALID) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (op_legal) begin
          state_nxt = S_EXECUTE;
        end else begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
          state_nxt = S_HALT;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
      S_EXECUTE: begin
        if (exec_cnt == 3'd0) state_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        WRITEENABLE = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // EXECUTE dwell counter covering ALU settling time
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      exec_cnt <= 3'd0;
    end else if (state == S_DECODE) begin
      exec_cnt <= EXEC_LOAD;
    end else if (state == S_EXECUTE && exec_cnt != 3'd0) begin
      exec_cnt <= exec_cnt - 3'd1;
    end
  end

  // Stage p1: decoded controls, held until the next legal DECODE
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ALUOP     <= 3'b000;
      READREG1  <= '0;
      READREG2  <= '0;
      WRITEREG  <= '0;
      IMMEDIATE <= '0;
      IMM_SEL   <= 1'b0;
      NEG_SEL   <= 1'b0;
    end else if (state == S_DECODE && op_legal) begin
      ALUOP     <= op_aluop;
      READREG1  <= instr_p0[8 +: REG_ADDR_W];
      READREG2  <= instr_p0[0 +: REG_ADDR_W];
      WRITEREG  <= instr_p0[16 +: REG_ADDR_W];
      IMMEDIATE <= DATA_W'(instr_p0[7:0]);
      IMM_SEL   <= op_imm;
      NEG_SEL   <= op_neg;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ILLEGAL <= 1'b0;
    end else if (state == S_DECODE && !op_legal) begin
      ILLEGAL <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench for alu_control_sequencer: random and directed instructions checked against an opcode-table model.
`timescale 1ns/1ps
module tb_alu_control_sequencer;
  localparam int EC = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        valid = 1'b0;
  logic        ready;
  logic [2:0]  aluop;
  logic [2:0]  rr1, rr2, wr;
  logic [7:0]  imm;
  logic        isel, nsel, we, busy;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  always #5 clk = ~clk;

  alu_control_sequencer #(.DATA_W(8), .REG_ADDR_W(3), .EXEC_CYCLES(EC)) dut (
    .CLK(clk), .RESET(rst_n), .INSTRUCTION(instr), .INSTR_VALID(valid),
    .INSTR_READY(ready), .ALUOP(aluop), .READREG1(rr1), .READREG2(rr2),
    .WRITEREG(wr), .IMMEDIATE(imm), .IMM_SEL(isel), .NEG_SEL(nsel),
    .WRITEENABLE(we),
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    .ILLEGAL(illegal),
`endif
    .BUSY(busy)
  );

  typedef struct packed {
    logic [2:0] aluop;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] wr;
    logic [7:0] imm;
    logic       isel;
    logic       nsel;
  } ctrl_t;

  typedef struct packed {
    int    cyc;
    ctrl_t c;
  } exp_t;

  exp_t  sb[$];
  ctrl_t last_done = '0;
  ctrl_t act, dc;
  exp_t  e;
  int    model_cnt = 0;
  bit    halted = 0, pend_halt = 0, rst_seen = 0, model_ready;
  int    cyc = 0, acc_cnt = 0;
  int    errors = 0, checks = 0;

  function automatic bit ref_decode(input logic [31:0] w, output ctrl_t c);
    c = '0;
    c.wr  = w[18:16];
    c.r1  = w[10:8];
    c.r2  = w[2:0];
    c.imm = w[7:0];
    case (w[31:24])
      8'h00: c.isel = 1'b1;
      8'h01: c.aluop = 3'd0;
      8'h02: c.aluop = 3'd1;
      8'h03: begin c.aluop = 3'd1; c.nsel = 1'b1; end
      8'h04: c.aluop = 3'd2;
      8'h05: c.aluop = 3'd3;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor and reference model, evaluated away from the active edge
  always @(negedge clk) begin
    act = {aluop, rr1, rr2, wr, imm, isel, nsel};
    if (!rst_n) begin
      if (!rst_seen) begin
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_we", we, 0);
        check("reset_ctrl", act, 0);
      end
      rst_seen  = 1;
      sb.delete();
      model_cnt = 0;
      halted    = 0;
      pend_halt = 0;
      last_done = '0;
    end else begin
      rst_seen    = 0;
      model_ready = (model_cnt == 0) && !halted;
      check("ready", ready, model_ready);
      check("busy", busy, !model_ready);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      check("illegal", illegal, halted);
`endif
      if (we) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got WRITEENABLE=1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("write_cycle", cyc, e.cyc);
          check("ctrl_at_write", act, e.c);
          last_done = e.c;
        end
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
        checks++; errors++;
        $display("FAIL missing_write: got WRITEENABLE=0, expected 1 (cycle %0d)", cyc);
        e = sb.pop_front();
      end
      if (model_ready) check("idle_ctrl", act, last_done);
      if (valid && model_ready) begin
        acc_cnt++;
        if (ref_decode(instr, dc)) begin
          e.cyc = cyc + 2 + EC;
          e.c   = dc;
          sb.push_back(e);
          model_cnt = 2 + EC;
        end else begin
          model_cnt = 1;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
          pend_halt = 1;
`endif
        end
      end else if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0 && pend_halt) begin
          halted    = 1;
          pend_halt = 0;
        end
      end
    end
  end

  // Called and returns at 1ns past a rising edge
  task automatic issue(input logic [31:0] w, input bit keep);
    int start;
    bit ok;
    start = acc_cnt;
    ok    = 0;
    instr = w;
    valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (acc_cnt != start) begin ok = 1; break; end
    end
    #1;
    if (!keep) valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no handshake, expected one for 0x%08h", w);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (model_cnt == 0 && sb.size() == 0) begin ok = 1; break; end
    end
    #1;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got pending=%0d, expected 0", sb.size());
    end
  endtask

  initial begin
    int gap;
    logic [7:0] op;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(32'h0004_00FD, 0); wait_idle();
    issue(32'h0302_0507, 0); wait_idle();
    issue(32'h0401_0203, 1); issue(32'h0506_0102, 0); wait_idle();

    // Valid pulsed with a different word while busy must be ignored
    issue(32'h0203_0405, 0);
    @(posedge clk); #1 instr = 32'h0507_0707; valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0;
    wait_idle();

    for (int n = 0; n < 60; n++) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      op = 8'($urandom_range(0, 5));
`else
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(0, 5));
`endif
      gap = $urandom_range(0, 2);
      issue({op, 24'($urandom)}, gap == 0);
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
    end
    valid = 1'b0;
    wait_idle();

    issue(32'h0701_0203, 0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
`else
    wait_idle();
`endif

    // Reset during EXECUTE aborts the add with no write strobe
    issue(32'h0205_0102, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    issue(32'h0003_0011, 0); wait_idle();

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
